tick_scheduler: RTL and testbench

TICK_SCHEDULER -- requirements
Module: tick_scheduler

---
 rtl/tick_scheduler_if.sv | 26 ++
 rtl/tick_scheduler.sv | 142 ++++++++++++++
 tb/tb_tick_scheduler.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/tick_scheduler_if.sv
// rtl/tick_scheduler_if.sv - configuration and channel request/grant bundle for tick_scheduler
interface tick_scheduler_if #(
  parameter int DIV_W = 26,
  parameter int DLY_W = 16
);
  logic             cfgWe;
  logic [DIV_W-1:0] cfgDiv;
  logic             cfgAck;
  logic             cfgErr;
  logic [3:0]       reqIn;
  logic [4*DLY_W-1:0] reqDelay;
  logic [3:0]       grantOut;
  logic [3:0]       doneOut;
  logic             tickOut;
  logic             busy;

  modport slave (
    input  cfgWe, cfgDiv, reqIn, reqDelay,
    output cfgAck, cfgErr, grantOut, doneOut, tickOut, busy
  );

  modport master (
    output cfgWe, cfgDiv, reqIn, reqDelay,
    input  cfgAck, cfgErr, grantOut, doneOut, tickOut, busy
  );
endinterface

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - four-channel round-robin delay timer sharing one prescaler and one down-counter
module tick_scheduler #(
  parameter int DIV_W   = 26,
  parameter int DLY_W   = 16,
  parameter int DIV_RST = 5000
) (
  input  logic            clkIn,
  input  logic            resetN,
  tick_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, DONE} state_t;

  state_t           r_state;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_pre;
  logic [DLY_W-1:0] r_rem;
  logic [1:0]       r_owner;
  logic [1:0]       r_last;
  logic [3:0]       r_grant;
  logic [3:0]       r_done;
  logic             r_ack;
  logic             r_err;

  logic             w_tick;
  logic             w_any;
  logic [1:0]       w_pick;
  logic [1:0]       w_idx;
  logic [DLY_W-1:0] w_dly;
  logic             w_owner_req;

  assign w_tick      = (r_state == COUNT) && (r_pre == r_div);
  assign w_dly       = bus.reqDelay[int'(r_owner)*DLY_W +: DLY_W];
  assign w_owner_req = bus.reqIn[r_owner];

  // Search starts one past the last owner so every pending channel is served before a repeat.
  always_comb begin
    w_any  = 1'b0;
    w_pick = r_last;
    w_idx  = r_last;
    for (int k = 1; k <= 4; k++) begin
      w_idx = r_last + 2'(k);
      if (!w_any && bus.reqIn[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  always_ff @(posedge clkIn or negedge resetN) begin
    if (!resetN) begin
      r_state <= IDLE;
      r_div   <= DIV_W'(DIV_RST);
      r_pre   <= '0;
      r_rem   <= '0;
      r_owner <= 2'd0;
      r_last  <= 2'd3;
      r_grant <= 4'b0000;
      r_done  <= 4'b0000;
      r_ack   <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_ack  <= 1'b0;
      r_err  <= 1'b0;
      r_done <= 4'b0000;

      if (bus.cfgWe) begin
        if (r_state == IDLE) begin
          r_div <= bus.cfgDiv;
          r_ack <= 1'b1;
        end else begin
          r_err <= 1'b1;
        end
      end

      case (r_state)
        IDLE: begin
          r_pre <= '0;
          if (w_any) begin
            r_owner <= w_pick;
            r_grant <= 4'b0001 << w_pick;
            r_state <= LOAD;
          end
        end

        LOAD: begin
          r_pre <= '0;
          if (!w_owner_req) begin
            r_last  <= r_owner;
            r_grant <= 4'b0000;
            r_state <= IDLE;
          end else begin
            r_rem <= w_dly;
            if (w_dly == '0) begin
              r_done  <= r_grant;
              r_state <= DONE;
            end else begin
              r_state <= COUNT;
            end
          end
        end

        COUNT: begin
          if (!w_owner_req) begin
            r_pre   <= '0;
            r_last  <= r_owner;
            r_grant <= 4'b0000;
            r_state <= IDLE;
          end else if (w_tick) begin
            r_pre <= '0;
            if (r_rem != '0) begin
              r_rem <= r_rem - DLY_W'(1);
            end
            if (r_rem <= DLY_W'(1)) begin
              r_done  <= r_grant;
              r_state <= DONE;
            end
          end else begin
            r_pre <= r_pre + DIV_W'(1);
          end
        end

        DONE: begin
          r_pre   <= '0;
          r_last  <= r_owner;
          r_grant <= 4'b0000;
          r_state <= IDLE;
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.cfgAck   = r_ack;
  assign bus.cfgErr   = r_err;
  assign bus.grantOut = r_grant;
  assign bus.doneOut  = r_done;
  assign bus.tickOut  = w_tick;
  assign bus.busy     = (r_state != IDLE);

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed scoreboard bench for tick_scheduler
module tb_tick_scheduler;

  localparam int DIV_W = 26;
  localparam int DLY_W = 16;

  logic clkIn = 1'b0;
  logic resetN = 1'b0;

  tick_scheduler_if #(.DIV_W(DIV_W), .DLY_W(DLY_W)) bus ();

  tick_scheduler #(.DIV_W(DIV_W), .DLY_W(DLY_W), .DIV_RST(5000)) dut (
    .clkIn  (clkIn),
    .resetN (resetN),
    .bus    (bus)
  );

  always #5 clkIn = ~clkIn;

  localparam int EV_TICK  = 0;
  localparam int EV_DONE  = 1;
  localparam int EV_GRANT = 2;
  localparam int EV_ACK   = 3;
  localparam int EV_ERR   = 4;

  typedef struct {
    int       kind;
    int       at;
    logic [3:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   kcur   = 0;
  logic [3:0] prev_grant = 4'b0000;

  function automatic logic [63:0] enc(input int kind, input int at, input logic [3:0] val);
    return {8'(kind), 32'(at), 20'(val)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_ev(input int kind, input int at, input logic [3:0] val);
    ev_t e;
    e.kind = kind;
    e.at   = at;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic obs_ev(input string tag, input int kind, input logic [3:0] val);
    ev_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(tag, enc(kind, kcur, val), enc(e.kind, e.at, e.val));
    end else begin
      chk({tag, " unexpected"}, enc(kind, kcur, val), {64{1'b1}});
    end
  endtask

  task automatic step();
    @(posedge clkIn);
    #1;
  endtask

  task automatic mark();
    kcur       = 0;
    prev_grant = bus.grantOut;
  endtask

  task automatic watch(input string tag, input int ncyc);
    for (int n = 0; n < ncyc; n++) begin
      step();
      kcur++;
      bus.cfgWe = 1'b0;
      if (bus.cfgAck) obs_ev({tag, " ack"}, EV_ACK, 4'b0000);
      if (bus.cfgErr) obs_ev({tag, " err"}, EV_ERR, 4'b0000);
      if (prev_grant == 4'b0000 && bus.grantOut != 4'b0000)
        obs_ev({tag, " grant"}, EV_GRANT, bus.grantOut);
      prev_grant = bus.grantOut;
      if (bus.tickOut) obs_ev({tag, " tick"}, EV_TICK, 4'b0000);
      if (bus.doneOut != 4'b0000) obs_ev({tag, " done"}, EV_DONE, bus.doneOut);
    end
  endtask

  task automatic drained(input string tag);
    chk({tag, " pending"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  task automatic set_dly(input int ch, input int d);
    bus.reqDelay[ch*DLY_W +: DLY_W] = DLY_W'(d);
  endtask

  function automatic logic [63:0] outs();
    return 64'({bus.grantOut, bus.doneOut, bus.tickOut, bus.busy, bus.cfgAck, bus.cfgErr});
  endfunction

  initial begin
    bus.cfgWe    = 1'b0;
    bus.cfgDiv   = '0;
    bus.reqIn    = 4'b0000;
    bus.reqDelay = '0;

    // reset state
    #12;
    chk("reset outs", outs(), 64'd0);
    step();
    resetN = 1'b1;

    // divisor 4, channel 0, delay 3
    mark();
    bus.cfgWe = 1'b1; bus.cfgDiv = 26'd4; bus.reqIn = 4'b0001; set_dly(0, 3);
    expect_ev(EV_ACK, 1, 4'b0000);
    expect_ev(EV_GRANT, 1, 4'b0001);
    expect_ev(EV_TICK, 6, 4'b0000);
    expect_ev(EV_TICK, 11, 4'b0000);
    expect_ev(EV_TICK, 16, 4'b0000);
    expect_ev(EV_DONE, 17, 4'b0001);
    watch("t1", 1);
    chk("t1 busy", 64'(bus.busy), 64'd1);
    watch("t1", 16);
    bus.reqIn = 4'b0000;
    watch("t1", 3);
    chk("t1 idle", outs(), 64'd0);
    drained("t1");

    // write during COUNT is rejected and does not disturb tick spacing
    mark();
    bus.reqIn = 4'b0010; set_dly(1, 2);
    expect_ev(EV_GRANT, 1, 4'b0010);
    watch("t2", 3);
    bus.cfgWe = 1'b1; bus.cfgDiv = 26'd1;
    expect_ev(EV_ERR, 4, 4'b0000);
    expect_ev(EV_TICK, 6, 4'b0000);
    expect_ev(EV_TICK, 11, 4'b0000);
    expect_ev(EV_DONE, 12, 4'b0010);
    watch("t2", 9);
    bus.reqIn = 4'b0000;
    watch("t2", 2);
    drained("t2");

    // owner drops mid-COUNT, channel 2 waiting
    mark();
    bus.reqIn = 4'b0001; set_dly(0, 5); set_dly(2, 0);
    expect_ev(EV_GRANT, 1, 4'b0001);
    expect_ev(EV_TICK, 6, 4'b0000);
    watch("t3", 8);
    bus.reqIn = 4'b0100;
    watch("t3", 1);
    chk("t3 abort idle", outs(), 64'd0);
    expect_ev(EV_GRANT, 10, 4'b0100);
    expect_ev(EV_DONE, 11, 4'b0100);
    watch("t3", 2);
    bus.reqIn = 4'b0000;
    watch("t3", 2);
    drained("t3");

    // divisor 0 written alongside a new request, delay 5
    mark();
    bus.cfgWe = 1'b1; bus.cfgDiv = 26'd0; bus.reqIn = 4'b1000; set_dly(3, 5);
    expect_ev(EV_ACK, 1, 4'b0000);
    expect_ev(EV_GRANT, 1, 4'b1000);
    for (int t = 2; t <= 6; t++) expect_ev(EV_TICK, t, 4'b0000);
    expect_ev(EV_DONE, 7, 4'b1000);
    watch("t4", 7);
    bus.reqIn = 4'b0000;
    watch("t4", 2);
    drained("t4");

    // all channels held with zero delay rotate in order
    mark();
    bus.reqIn = 4'b1111;
    for (int ch = 0; ch < 4; ch++) set_dly(ch, 0);
    for (int r = 0; r < 5; r++) begin
      expect_ev(EV_GRANT, 1 + 3*r, 4'b0001 << (r % 4));
      expect_ev(EV_DONE, 2 + 3*r, 4'b0001 << (r % 4));
    end
    watch("t5", 14);
    bus.reqIn = 4'b0000;
    watch("t5", 2);
    drained("t5");

    // asynchronous reset mid-COUNT, then default divisor
    mark();
    bus.cfgWe = 1'b1; bus.cfgDiv = 26'd2; bus.reqIn = 4'b0100; set_dly(2, 10);
    expect_ev(EV_ACK, 1, 4'b0000);
    expect_ev(EV_GRANT, 1, 4'b0100);
    expect_ev(EV_TICK, 4, 4'b0000);
    watch("t6", 5);
    chk("t6 busy before reset", 64'(bus.busy), 64'd1);
    #2 resetN = 1'b0;
    #1;
    chk("t6 async reset outs", outs(), 64'd0);
    bus.reqIn = 4'b0000;
    drained("t6");
    step();
    resetN = 1'b1;
    mark();
    bus.reqIn = 4'b0001; set_dly(0, 2);
    expect_ev(EV_GRANT, 1, 4'b0001);
    expect_ev(EV_TICK, 5002, 4'b0000);
    expect_ev(EV_TICK, 10003, 4'b0000);
    expect_ev(EV_DONE, 10004, 4'b0001);
    watch("t6b", 10004);
    bus.reqIn = 4'b0000;
    watch("t6b", 2);
    chk("t6b idle", outs(), 64'd0);
    drained("t6b");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
